// File: rtl/count_seq_tracker_pkg.sv
// count_pkg: shared types and default widths for the count sequence tracker.
//   trk_state_e  - lock FSM state encoding
//   *_DEF        - default parameter values used by the interface and top
package count_pkg;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } trk_state_e;

  localparam int CW_DEF       = 3;
  localparam int EW_DEF       = 8;
  localparam int LOCK_LEN_DEF = 4;
  localparam int ERR_W_DEF    = 8;

endpackage

// File: rtl/count_seq_tracker_if.sv
// count_seq_tracker_if: bundle between the environment and the tracker.
//   master modport: environment side (drives count_in/count_vld/clr_stats,
//                   observes status and statistics)
//   slave modport : tracker side
interface count_seq_tracker_if #(
  parameter int CW    = count_pkg::CW_DEF,
  parameter int EW    = count_pkg::EW_DEF,
  parameter int ERR_W = count_pkg::ERR_W_DEF
) ();

  logic [CW-1:0]    count_in;
  logic             count_vld;
  logic             clr_stats;
  logic             locked;
  logic             wrap_pulse;
  logic             seq_err;
  logic [EW-1:0]    epoch;
  logic [EW+CW-1:0] ext_count;
  logic [ERR_W-1:0] err_cnt;

  modport master (
    output count_in, count_vld, clr_stats,
    input  locked, wrap_pulse, seq_err, epoch, ext_count, err_cnt
  );

  modport slave (
    input  count_in, count_vld, clr_stats,
    output locked, wrap_pulse, seq_err, epoch, ext_count, err_cnt
  );

endinterface

// File: rtl/count_seq_tracker_sat_counter.sv
// sat_counter: W-bit event counter with synchronous clear.
//   clk   - clock, rising edge
//   rst   - asynchronous reset, active low
//   clr   - synchronous clear to 0 (wins over inc)
//   inc   - count one event
//   value - current count (registered)
// With SAT=1 the count sticks at all-ones; with SAT=0 it wraps modulo 2^W.
module sat_counter #(
  parameter int W   = 8,
  parameter bit SAT = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] value
);

  logic [W-1:0] value_reg;
  logic [W-1:0] value_next;
  logic         hold_max;

  assign hold_max = SAT && (&value_reg);

  always_comb begin
    value_next = value_reg;
    if (clr) begin
      value_next = '0;
    end else if (inc && !hold_max) begin
      value_next = value_reg + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value_reg <= '0;
    end else begin
      value_reg <= value_next;
    end
  end

  assign value = value_reg;

endmodule

// File: rtl/count_seq_tracker.sv
// count_seq_tracker: checks that an upstream counter advances by exactly +1
// (mod 2^CW) every clock, counts wrap-arounds into an epoch, and runs a lock
// FSM that reports sequence errors once locked.
//   clk - clock, rising edge
//   rst - asynchronous reset, active low
//   bus - slave side of count_seq_tracker_if:
//         count_in/count_vld/clr_stats in;
//         locked, wrap_pulse, seq_err, epoch, ext_count, err_cnt out.
// All outputs are registered: a transition compared at edge t+1 (against the
// sample taken at edge t) is reported after edge t+1.
module count_seq_tracker
  import count_pkg::*;
#(
  parameter int CW       = CW_DEF,
  parameter int EW       = EW_DEF,
  parameter int LOCK_LEN = LOCK_LEN_DEF,
  parameter int ERR_W    = ERR_W_DEF
) (
  input logic                clk,
  input logic                rst,
  count_seq_tracker_if.slave bus
);

  // LOCK_LEN is limited to 1..15, so a 4-bit run length is enough.
  localparam int RL_W = 4;

  trk_state_e    state_reg, state_next;
  logic [RL_W-1:0] run_len_reg, run_len_next;
  logic [RL_W-1:0] run_len_inc;
  logic [CW-1:0] prev_cnt_reg;
  logic          prev_vld_reg;
  logic          locked_reg;
  logic          wrap_reg;
  logic          seq_err_reg;

  logic [CW-1:0] expected;
  logic          match;
  logic          wrap_hit;
  logic          err_hit;
  logic [EW-1:0]    epoch_val;
  logic [ERR_W-1:0] err_val;

  assign expected    = prev_cnt_reg + CW'(1);
  assign match       = prev_vld_reg & bus.count_vld & (bus.count_in == expected);
  // Only a matched max->0 step is a wrap; a jump to 0 from elsewhere is not.
  assign wrap_hit    = match & (&prev_cnt_reg);
  assign run_len_inc = run_len_reg + RL_W'(1);

  always_comb begin
    state_next   = state_reg;
    run_len_next = run_len_reg;
    err_hit      = 1'b0;
    case (state_reg)
      UNLOCKED: begin
        if (bus.count_vld) begin
          state_next   = ACQUIRE;
          run_len_next = '0;
        end
      end
      ACQUIRE: begin
        if (!bus.count_vld) begin
          state_next   = UNLOCKED;
          run_len_next = '0;
        end else if (!match) begin
          run_len_next = '0;
        end else begin
          run_len_next = run_len_inc;
          if (run_len_inc == RL_W'(LOCK_LEN)) begin
            state_next = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (!bus.count_vld) begin
          state_next   = UNLOCKED;
          run_len_next = '0;
        end else if (!match) begin
          // A stalled or jumping count both land here.
          err_hit      = 1'b1;
          state_next   = ACQUIRE;
          run_len_next = '0;
        end
      end
      default: begin
        state_next   = UNLOCKED;
        run_len_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= UNLOCKED;
      run_len_reg  <= '0;
      prev_cnt_reg <= '0;
      prev_vld_reg <= 1'b0;
      locked_reg   <= 1'b0;
      wrap_reg     <= 1'b0;
      seq_err_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      run_len_reg  <= run_len_next;
      prev_vld_reg <= bus.count_vld;
      if (bus.count_vld) begin
        prev_cnt_reg <= bus.count_in;
      end
      locked_reg   <= (state_next == LOCKED);
      wrap_reg     <= wrap_hit;
      seq_err_reg  <= err_hit;
    end
  end

  // clr_stats takes priority inside the counters; the pulses above still fire.
  sat_counter #(.W(EW), .SAT(1'b0)) u_epoch (
    .clk   (clk),
    .rst   (rst),
    .clr   (bus.clr_stats),
    .inc   (wrap_hit),
    .value (epoch_val)
  );

  sat_counter #(.W(ERR_W), .SAT(1'b1)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (bus.clr_stats),
    .inc   (err_hit),
    .value (err_val)
  );

  assign bus.locked     = locked_reg;
  assign bus.wrap_pulse = wrap_reg;
  assign bus.seq_err    = seq_err_reg;
  assign bus.epoch      = epoch_val;
  // Both halves are registers updated on the same edge, so they never tear.
  assign bus.ext_count  = {epoch_val, prev_cnt_reg};
  assign bus.err_cnt    = err_val;

endmodule

// File: tb/tb_count_seq_tracker.sv
// tb_count_seq_tracker: directed self-checking bench for count_seq_tracker.
module tb_count_seq_tracker;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  int   cur;
  int   nxt;
  int   exp_err;

  count_seq_tracker_if #(.CW(3), .EW(8), .ERR_W(8)) bus ();

  count_seq_tracker #(.CW(3), .EW(8), .LOCK_LEN(4), .ERR_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one sample: inputs change 1 time unit after an edge, are sampled at
  // the next rising edge, and outputs are examined 1 unit after that edge.
  task automatic tick(input int c, input bit v, input bit clr);
    bus.count_in  = 3'(c);
    bus.count_vld = v;
    bus.clr_stats = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    $display("[%0t] %s observed=%0d expected=%0d", $time, tag, obs, exp);
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    rst           = 1'b0;
    bus.count_in  = '0;
    bus.count_vld = 1'b0;
    bus.clr_stats = 1'b0;

    // Reset state
    @(posedge clk);
    #1;
    chk("rst_locked",  32'(bus.locked), 0);
    chk("rst_wrap",    32'(bus.wrap_pulse), 0);
    chk("rst_seq_err", 32'(bus.seq_err), 0);
    chk("rst_epoch",   32'(bus.epoch), 0);
    chk("rst_ext",     32'(bus.ext_count), 0);
    chk("rst_err_cnt", 32'(bus.err_cnt), 0);
    rst = 1'b1;

    // Initial lock: first sample 0, then 4 correct increments -> locked after 5th edge
    for (int i = 0; i <= 4; i++) begin
      tick(i, 1'b1, 1'b0);
      chk("lock_locked",  32'(bus.locked), (i == 4) ? 1 : 0);
      chk("lock_seq_err", 32'(bus.seq_err), 0);
    end
    chk("lock_ext", 32'(bus.ext_count), 4);
    cur = 4;

    // 20 full cycles: one wrap pulse per 7->0
    for (int v = 5; v <= 7; v++) begin
      tick(v, 1'b1, 1'b0);
      chk("run_wrap", 32'(bus.wrap_pulse), 0);
    end
    for (int k = 0; k < 20; k++) begin
      for (int v = 0; v <= 7; v++) begin
        tick(v, 1'b1, 1'b0);
        chk("run_wrap", 32'(bus.wrap_pulse), (v == 0) ? 1 : 0);
        chk("run_seq_err", 32'(bus.seq_err), 0);
        if (v == 0) chk("run_epoch", 32'(bus.epoch), 32'(k + 1));
      end
    end
    chk("run_epoch_final", 32'(bus.epoch), 20);
    chk("run_ext_final",   32'(bus.ext_count), 20 * 8 + 7);
    chk("run_locked",      32'(bus.locked), 1);
    chk("run_err_cnt",     32'(bus.err_cnt), 0);

    // Jump 3->5 while locked
    tick(0, 1'b1, 1'b0);
    chk("jump_epoch", 32'(bus.epoch), 21);
    tick(1, 1'b1, 1'b0);
    tick(2, 1'b1, 1'b0);
    tick(3, 1'b1, 1'b0);
    tick(5, 1'b1, 1'b0);
    chk("jump_seq_err", 32'(bus.seq_err), 1);
    chk("jump_err_cnt", 32'(bus.err_cnt), 1);
    chk("jump_locked",  32'(bus.locked), 0);
    tick(6, 1'b1, 1'b0);
    chk("jump_seq_err_once", 32'(bus.seq_err), 0);
    tick(7, 1'b1, 1'b0);
    tick(0, 1'b1, 1'b0);
    chk("acq_wrap",  32'(bus.wrap_pulse), 1);
    chk("acq_epoch", 32'(bus.epoch), 22);
    chk("acq_locked", 32'(bus.locked), 0);
    tick(1, 1'b1, 1'b0);
    chk("relock", 32'(bus.locked), 1);

    // Clear stats on a plain increment, then hold the count at 2
    tick(2, 1'b1, 1'b1);
    chk("clr_epoch",   32'(bus.epoch), 0);
    chk("clr_err_cnt", 32'(bus.err_cnt), 0);
    chk("clr_ext",     32'(bus.ext_count), 2);
    chk("clr_seq_err", 32'(bus.seq_err), 0);
    tick(2, 1'b1, 1'b0);
    chk("hold1_seq_err", 32'(bus.seq_err), 1);
    chk("hold1_locked",  32'(bus.locked), 0);
    tick(2, 1'b1, 1'b0);
    chk("hold2_seq_err", 32'(bus.seq_err), 0);
    tick(2, 1'b1, 1'b0);
    chk("hold3_seq_err", 32'(bus.seq_err), 0);
    chk("hold_err_cnt",  32'(bus.err_cnt), 1);

    // Relock and wrap once so epoch is non-zero before dropping count_vld
    for (int v = 3; v <= 7; v++) tick(v, 1'b1, 1'b0);
    tick(0, 1'b1, 1'b0);
    chk("pre_drop_wrap", 32'(bus.wrap_pulse), 1);
    tick(1, 1'b1, 1'b0);
    chk("pre_drop_locked", 32'(bus.locked), 1);
    chk("pre_drop_epoch",  32'(bus.epoch), 1);

    // count_vld low for two cycles, then restart from 0
    tick(3, 1'b0, 1'b0);
    chk("drop_locked",  32'(bus.locked), 0);
    chk("drop_seq_err", 32'(bus.seq_err), 0);
    chk("drop_ext",     32'(bus.ext_count), 9);
    tick(4, 1'b0, 1'b0);
    chk("drop2_seq_err", 32'(bus.seq_err), 0);
    chk("drop2_epoch",   32'(bus.epoch), 1);
    tick(0, 1'b1, 1'b0);
    chk("restart_wrap",    32'(bus.wrap_pulse), 0);
    chk("restart_seq_err", 32'(bus.seq_err), 0);
    chk("restart_ext",     32'(bus.ext_count), 8);
    for (int v = 1; v <= 4; v++) begin
      tick(v, 1'b1, 1'b0);
      chk("restart_locked", 32'(bus.locked), (v == 4) ? 1 : 0);
    end
    chk("restart_err_cnt", 32'(bus.err_cnt), 1);
    cur = 4;

    // Repeated errors drive err_cnt to saturation and keep it there
    for (int r = 1; r <= 255; r++) begin
      nxt = (cur + 2) % 8;
      tick(nxt, 1'b1, 1'b0);
      exp_err = (r + 1 > 255) ? 255 : r + 1;
      chk("sat_seq_err", 32'(bus.seq_err), 1);
      chk("sat_err_cnt", 32'(bus.err_cnt), 32'(exp_err));
      cur = nxt;
      for (int j = 0; j < 4; j++) begin
        cur = (cur + 1) % 8;
        tick(cur, 1'b1, 1'b0);
      end
    end
    chk("sat_final_err_cnt", 32'(bus.err_cnt), 255);
    chk("sat_final_locked",  32'(bus.locked), 1);

    // clr_stats coincident with a 7->0 wrap: pulse still seen, clear wins
    while (cur != 7) begin
      cur = (cur + 1) % 8;
      tick(cur, 1'b1, 1'b0);
    end
    tick(0, 1'b1, 1'b1);
    chk("clrwrap_wrap",    32'(bus.wrap_pulse), 1);
    chk("clrwrap_epoch",   32'(bus.epoch), 0);
    chk("clrwrap_ext",     32'(bus.ext_count), 0);
    chk("clrwrap_err_cnt", 32'(bus.err_cnt), 0);
    chk("clrwrap_locked",  32'(bus.locked), 1);

    // Asynchronous reset between clock edges
    for (int v = 1; v <= 7; v++) tick(v, 1'b1, 1'b0);
    tick(0, 1'b1, 1'b0);
    chk("prerst_wrap",   32'(bus.wrap_pulse), 1);
    chk("prerst_epoch",  32'(bus.epoch), 1);
    chk("prerst_locked", 32'(bus.locked), 1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_locked",  32'(bus.locked), 0);
    chk("arst_wrap",    32'(bus.wrap_pulse), 0);
    chk("arst_seq_err", 32'(bus.seq_err), 0);
    chk("arst_epoch",   32'(bus.epoch), 0);
    chk("arst_ext",     32'(bus.ext_count), 0);
    chk("arst_err_cnt", 32'(bus.err_cnt), 0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
